cpu_lsu: RTL and testbench
==========================

// Module: cpu_lsu
// PURPOSE
//  Load/store unit bridging the multicycle CPU datapath to a wait-state memory bus (req/gnt/rvalid).
//  Adds sub-word accesses (byte/half), byte enables, misalignment detection and bus timeout,
//  none of which exist on the current zero-wait single-port memory path.
//  Sits between the core datapath/control FSM (which stalls on core_busy) and the memory/interconnect.
// PARAMETERS
//  ADDR_WIDTH     32  byte-address width, core and bus side
//  DATA_WIDTH     32  bus data width; legal values 32 or 64
//  TIMEOUT_CYCLES 16  max cycles in REQ+WAIT before error; >=2
// PORTS
//  sys_clk      in   1               system clock, all logic on posedge
//  sys_rst      in   1               synchronous, active-high reset
//  core_req     in   1               access request, sampled in IDLE only
//  core_we      in   1               1 store, 0 load
//  core_size    in   2               00 byte, 01 half, 10 word, 11 dword (legal only if DATA_WIDTH==64)
//  core_uns     in   1               1 zero-extend load, 0 sign-extend
//  core_addr    in   ADDR_WIDTH      byte address
//  core_wdata   in   DATA_WIDTH      store data, LSB-justified
//  core_busy    out  1               high from cycle after accepted core_req until done pulse, inclusive
//  core_done    out  1               1-cycle completion pulse
//  core_err     out  1               valid with core_done: misaligned, illegal size or timeout
//  core_rdata   out  DATA_WIDTH      extended load data, valid with core_done (0 on store/error)
//  bus_req      out  1               bus request, held until bus_gnt
//  bus_gnt      in   1               bus accepts request this cycle
//  bus_we       out  1               write strobe qualifier
//  bus_addr     out  ADDR_WIDTH      address aligned to DATA_WIDTH/8 bytes
//  bus_be       out  DATA_WIDTH/8    byte enables, lane = addr offset
//  bus_wdata    out  DATA_WIDTH      store data shifted onto lanes
//  bus_rvalid   in   1               read data valid, never earlier than cycle after gnt
//  bus_rdata    in   DATA_WIDTH      read data, full bus word
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; timeout counter 0; captured request registers 0.
//  FSM states IDLE, REQ, WAIT, DONE:
//   IDLE: core_req & legal & aligned -> REQ, capture we/size/uns/addr/wdata.
//         core_req & (misaligned | illegal size) -> DONE with err=1; no bus activity.
//   REQ : bus_req=1, bus_* driven from captured regs, stable until gnt.
//         gnt & we -> DONE (stores complete on grant); gnt & !we -> WAIT.
//   WAIT: bus_rvalid -> DONE, capture extended rdata.
//   DONE: core_done=1 (one cycle), core_err/core_rdata valid -> IDLE.
//  Alignment: half needs addr[0]==0, word addr[1:0]==0, dword addr[2:0]==0.
//  Lanes: off = addr mod DATA_WIDTH/8; byte be=1<<off, half be=3<<off, word be=F<<off, dword all-ones.
//   bus_wdata = core_wdata << 8*off; load data = (bus_rdata >> 8*off) truncated to size, then sign/zero
//   extended to DATA_WIDTH per core_uns.
//  Latency: core_req cycle 0 -> bus_req cycle 1; with gnt cycle 1 and rvalid cycle 2, core_done cycle 3.
//   Store with gnt cycle 1 -> core_done cycle 2. Misaligned -> core_done+err cycle 1.
//  Timeout: counter clears on IDLE->REQ, increments each cycle in REQ/WAIT; reaching TIMEOUT_CYCLES-1
//   without the exit event -> DONE with err=1, bus_req drops. A late bus_rvalid after timeout is ignored.
//  core_req while busy ignored (not queued). bus_gnt/bus_rvalid outside REQ/WAIT ignored.
//  Simultaneous gnt and timeout expiry in REQ: grant wins (no error).
//  Reset mid-operation: next edge returns to IDLE, bus_req=0, no core_done emitted; pending rvalid dropped.
// STRUCTURE
//  pkg_cpu_typedefs: lsu_state_t {IDLE,REQ,WAIT,DONE}; lsu_size_t {LSU_B,LSU_H,LSU_W,LSU_D}.
//  Sub-module cpu_lsu_align (combinational): alignment check, be generation, wdata shift, rdata
//  extract/extend; cpu_lsu holds FSM, capture registers and timeout counter.
// TESTING
//  Word load addr 0x100, gnt cyc1, rvalid cyc2 rdata 0xDEADBEEF -> done cyc3, rdata 0xDEADBEEF, be 0xF.
//  Signed byte load addr 0x103, rdata 0x80000000 -> bus_addr 0x100, be 0x8, rdata 0xFFFFFF80; uns -> 0x80.
//  Half store addr 0x202 wdata 0x1234, gnt after 3 wait cycles -> bus_wdata 0x12340000, be 0xC, done 1 cycle later.
//  Word load addr 0x101 -> no bus_req, done+err cycle 1; size 11 at DATA_WIDTH=32 -> same.
//  No gnt for TIMEOUT_CYCLES cycles -> err=1, bus_req low; later rvalid ignored, next req works.
//  sys_rst asserted in WAIT -> IDLE next edge, all outputs 0, no done pulse, subsequent load correct.

Source files
------------

// File: rtl/cpu_lsu_pkg.sv
// Shared types for the load/store unit: FSM states and access sizes.
package pkg_cpu_typedefs;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

   typedef enum logic [1:0] {LSU_B, LSU_H, LSU_W, LSU_D} lsu_size_t;

endpackage

// File: rtl/cpu_lsu_align.sv
// Combinational lane logic for the LSU: alignment/size legality, byte enables,
// store data lane shift and load data extraction with sign/zero extension.
module cpu_lsu_align
   import pkg_cpu_typedefs::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic [2:0]              chk_off_i,
   input  logic [1:0]              chk_size_i,
   output logic                    chk_bad_o,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic [1:0]              size_i,
   input  logic                    uns_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   input  logic [DATA_WIDTH-1:0]   rdata_i,
   output logic [ADDR_WIDTH-1:0]   addr_o,
   output logic [DATA_WIDTH/8-1:0] be_o,
   output logic [DATA_WIDTH-1:0]   wdata_o,
   output logic [DATA_WIDTH-1:0]   rdata_o
);

   localparam int NB   = DATA_WIDTH / 8;
   localparam int OFFW = $clog2(NB);

   logic [OFFW-1:0]       off;
   logic [OFFW+2:0]       bit_sh;
   logic [NB-1:0]         base_be;
   logic [DATA_WIDTH-1:0] rd_sh;

   function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] v,
                                                    input lsu_size_t sz,
                                                    input logic uns);
      logic [DATA_WIDTH-1:0] r;
      r = v;
      case (sz)
         LSU_B: begin
            if (uns) r = DATA_WIDTH'(v[7:0]);
            else     r = DATA_WIDTH'($signed(v[7:0]));
         end
         LSU_H: begin
            if (uns) r = DATA_WIDTH'(v[15:0]);
            else     r = DATA_WIDTH'($signed(v[15:0]));
         end
         LSU_W: begin
            if (uns) r = DATA_WIDTH'(v[31:0]);
            else     r = DATA_WIDTH'($signed(v[31:0]));
         end
         default: r = v;
      endcase
      return r;
   endfunction

   assign off     = addr_i[OFFW-1:0];
   assign bit_sh  = {off, 3'b000};
   assign addr_o  = addr_i & ~ADDR_WIDTH'(NB - 1);
   assign wdata_o = wdata_i << bit_sh;
   assign rd_sh   = rdata_i >> bit_sh;
   assign be_o    = base_be << off;
   assign rdata_o = extend(rd_sh, lsu_size_t'(size_i), uns_i);

   // Dword is only a legal size when the bus is 64 bits wide.
   always_comb begin
      chk_bad_o = 1'b0;
      case (lsu_size_t'(chk_size_i))
         LSU_B:   chk_bad_o = 1'b0;
         LSU_H:   chk_bad_o = chk_off_i[0];
         LSU_W:   chk_bad_o = |chk_off_i[1:0];
         default: chk_bad_o = (DATA_WIDTH != 64) || (chk_off_i != 3'b000);
      endcase
   end

   always_comb begin
      base_be = '1;
      case (lsu_size_t'(size_i))
         LSU_B:   base_be = NB'(1);
         LSU_H:   base_be = NB'(3);
         LSU_W:   base_be = NB'(15);
         default: base_be = '1;
      endcase
   end

endmodule

// File: rtl/cpu_lsu.sv
// Load/store unit: accepts one core access at a time, runs it over a req/gnt/rvalid
// memory bus with a timeout, and returns a one-cycle done pulse with error and load data.
module cpu_lsu
   import pkg_cpu_typedefs::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                    sys_clk,
   input  logic                    sys_rst,
   input  logic                    core_req,
   input  logic                    core_we,
   input  logic [1:0]              core_size,
   input  logic                    core_uns,
   input  logic [ADDR_WIDTH-1:0]   core_addr,
   input  logic [DATA_WIDTH-1:0]   core_wdata,
   output logic                    core_busy,
   output logic                    core_done,
   output logic                    core_err,
   output logic [DATA_WIDTH-1:0]   core_rdata,
   output logic                    bus_req,
   input  logic                    bus_gnt,
   output logic                    bus_we,
   output logic [ADDR_WIDTH-1:0]   bus_addr,
   output logic [DATA_WIDTH/8-1:0] bus_be,
   output logic [DATA_WIDTH-1:0]   bus_wdata,
   input  logic                    bus_rvalid,
   input  logic [DATA_WIDTH-1:0]   bus_rdata
);

   localparam int NB    = DATA_WIDTH / 8;
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

   lsu_state_t            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  we_q, we_d;
   lsu_size_t             size_q, size_d;
   logic                  uns_q, uns_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic                  chk_bad;
   logic                  cnt_last;
   logic [ADDR_WIDTH-1:0] lane_addr;
   logic [NB-1:0]         lane_be;
   logic [DATA_WIDTH-1:0] lane_wdata;
   logic [DATA_WIDTH-1:0] lane_rdata;

   cpu_lsu_align #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_align (
      .chk_off_i  (core_addr[2:0]),
      .chk_size_i (core_size),
      .chk_bad_o  (chk_bad),
      .addr_i     (addr_q),
      .size_i     (size_q),
      .uns_i      (uns_q),
      .wdata_i    (wdata_q),
      .rdata_i    (bus_rdata),
      .addr_o     (lane_addr),
      .be_o       (lane_be),
      .wdata_o    (lane_wdata),
      .rdata_o    (lane_rdata)
   );

   assign cnt_last   = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   assign core_busy  = (state_q != IDLE);
   assign core_done  = (state_q == DONE);
   assign core_err   = core_done & err_q;
   assign core_rdata = core_done ? rdata_q : '0;

   // Bus outputs are forced to zero outside REQ so the bus sees nothing stale.
   assign bus_req    = (state_q == REQ);
   assign bus_we     = bus_req & we_q;
   assign bus_addr   = bus_req ? lane_addr  : '0;
   assign bus_be     = bus_req ? lane_be    : '0;
   assign bus_wdata  = bus_req ? lane_wdata : '0;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      size_d  = size_q;
      uns_d   = uns_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (core_req) begin
               err_d   = 1'b0;
               rdata_d = '0;
               if (chk_bad) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  we_d    = core_we;
                  size_d  = lsu_size_t'(core_size);
                  uns_d   = core_uns;
                  addr_d  = core_addr;
                  wdata_d = core_wdata;
                  cnt_d   = '0;
                  state_d = REQ;
               end
            end
         end
         // Grant is checked before expiry so a grant in the last cycle still succeeds.
         REQ: begin
            if (bus_gnt) begin
               state_d = we_q ? DONE : WAIT;
               if (!cnt_last) cnt_d = cnt_q + CNT_W'(1);
            end else if (cnt_last) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WAIT: begin
            if (bus_rvalid) begin
               rdata_d = lane_rdata;
               state_d = DONE;
            end else if (cnt_last) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         size_q  <= LSU_B;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

endmodule

// File: tb/tb_cpu_lsu.sv
// Scoreboard bench for cpu_lsu at ADDR_WIDTH=32, DATA_WIDTH=32, TIMEOUT_CYCLES=16.
module tb_cpu_lsu;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic        core_req, core_we, core_uns;
   logic [1:0]  core_size;
   logic [31:0] core_addr, core_wdata;
   logic        core_busy, core_done, core_err;
   logic [31:0] core_rdata;
   logic        bus_req, bus_gnt, bus_we, bus_rvalid;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_be;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb[$];

   always #5 sys_clk = ~sys_clk;

   cpu_lsu #(
      .ADDR_WIDTH     (32),
      .DATA_WIDTH     (32),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .core_req   (core_req),
      .core_we    (core_we),
      .core_size  (core_size),
      .core_uns   (core_uns),
      .core_addr  (core_addr),
      .core_wdata (core_wdata),
      .core_busy  (core_busy),
      .core_done  (core_done),
      .core_err   (core_err),
      .core_rdata (core_rdata),
      .bus_req    (bus_req),
      .bus_gnt    (bus_gnt),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_be     (bus_be),
      .bus_wdata  (bus_wdata),
      .bus_rvalid (bus_rvalid),
      .bus_rdata  (bus_rdata)
   );

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
      core_req   = 1'b1;
      core_we    = we;
      core_size  = sz;
      core_uns   = uns;
      core_addr  = addr;
      core_wdata = wd;
      step();
      core_req   = 1'b0;
   endtask

   task automatic test_reset();
      sys_rst = 1'b1; core_req = 1'b1; core_we = 1'b0; core_size = 2'd2; core_uns = 1'b0;
      core_addr = 32'h100; core_wdata = '0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
      step(); step();
      total++;
      if ({core_busy, core_done, core_err, bus_req, bus_we} !== 5'b0) begin
         bad++; $display("FAIL reset_ctrl got=%b want=00000", {core_busy, core_done, core_err, bus_req, bus_we});
      end
      total++;
      if (core_rdata !== 32'h0 || bus_addr !== 32'h0) begin
         bad++; $display("FAIL reset_data rdata=%h addr=%h want=0", core_rdata, bus_addr);
      end
      total++;
      if (bus_be !== 4'h0 || bus_wdata !== 32'h0) begin
         bad++; $display("FAIL reset_bus be=%h wdata=%h want=0", bus_be, bus_wdata);
      end
      core_req = 1'b0;
      sys_rst  = 1'b0;
      step();
   endtask

   task automatic test_word_load();
      exp_t e;
      sb.push_back('{err: 1'b0, rdata: 32'hDEADBEEF});
      issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
      total++;
      if ({bus_req, bus_we, bus_addr, bus_be} !== {1'b1, 1'b0, 32'h100, 4'hF}) begin
         bad++; $display("FAIL wl_bus req=%b we=%b addr=%h be=%h want 1 0 00000100 f", bus_req, bus_we, bus_addr, bus_be);
      end
      bus_gnt = 1'b1;
      step();
      bus_gnt = 1'b0;
      total++;
      if (bus_req !== 1'b0 || core_busy !== 1'b1) begin
         bad++; $display("FAIL wl_wait req=%b busy=%b want 0 1", bus_req, core_busy);
      end
      bus_rvalid = 1'b1; bus_rdata = 32'hDEADBEEF;
      step();
      bus_rvalid = 1'b0;
      total++;
      if (core_done !== 1'b1) begin
         bad++; $display("FAIL wl_latency done=%b want 1 at cycle 3", core_done);
      end
      e = sb.pop_front();
      total++;
      if ({core_err, core_rdata} !== {e.err, e.rdata}) begin
         bad++; $display("FAIL wl_data err=%b rdata=%h want %b %h", core_err, core_rdata, e.err, e.rdata);
      end
      step();
      total++;
      if (core_done !== 1'b0 || core_busy !== 1'b0) begin
         bad++; $display("FAIL wl_pulse done=%b busy=%b want 0 0", core_done, core_busy);
      end
   endtask

   task automatic test_byte_load();
      exp_t e;
      for (int u = 0; u < 2; u++) begin
         sb.push_back('{err: 1'b0, rdata: (u == 1) ? 32'h00000080 : 32'hFFFFFF80});
         issue(1'b0, 2'd0, u[0], 32'h103, 32'h0);
         total++;
         if (bus_addr !== 32'h100 || bus_be !== 4'h8) begin
            bad++; $display("FAIL bl_bus uns=%0d addr=%h be=%h want 00000100 8", u, bus_addr, bus_be);
         end
         bus_gnt = 1'b1;
         step();
         bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h80000000;
         step();
         bus_rvalid = 1'b0;
         e = sb.pop_front();
         total++;
         if ({core_done, core_err, core_rdata} !== {1'b1, e.err, e.rdata}) begin
            bad++; $display("FAIL bl_data uns=%0d done=%b err=%b rdata=%h want 1 %b %h", u, core_done, core_err, core_rdata, e.err, e.rdata);
         end
         step();
      end
   endtask

   task automatic test_half_store();
      exp_t e;
      sb.push_back('{err: 1'b0, rdata: 32'h0});
      issue(1'b1, 2'd1, 1'b0, 32'h202, 32'h00001234);
      for (int i = 0; i < 4; i++) begin
         total++;
         if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata} !== {1'b1, 1'b1, 32'h200, 4'hC, 32'h12340000}) begin
            bad++; $display("FAIL hs_bus cyc=%0d req=%b we=%b addr=%h be=%h wdata=%h want 1 1 00000200 c 12340000",
                            i, bus_req, bus_we, bus_addr, bus_be, bus_wdata);
         end
         if (i == 3) bus_gnt = 1'b1;
         step();
      end
      bus_gnt = 1'b0;
      e = sb.pop_front();
      total++;
      if ({core_done, core_err, core_rdata, bus_req} !== {1'b1, e.err, e.rdata, 1'b0}) begin
         bad++; $display("FAIL hs_done done=%b err=%b rdata=%h req=%b want 1 0 0 0", core_done, core_err, core_rdata, bus_req);
      end
      step();
   endtask

   task automatic test_misaligned();
      logic [1:0]  sz_tab[3]   = '{2'd2, 2'd3, 2'd1};
      logic [31:0] addr_tab[3] = '{32'h101, 32'h100, 32'h201};
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         sb.push_back('{err: 1'b1, rdata: 32'h0});
         issue(1'b0, sz_tab[i], 1'b0, addr_tab[i], 32'h0);
         e = sb.pop_front();
         total++;
         if ({core_done, core_err, core_rdata, bus_req} !== {1'b1, e.err, e.rdata, 1'b0}) begin
            bad++; $display("FAIL mis_%0d done=%b err=%b rdata=%h req=%b want 1 1 0 0", i, core_done, core_err, core_rdata, bus_req);
         end
         step();
      end
   endtask

   task automatic test_timeout();
      exp_t e;
      int   n;
      bit   seen;
      sb.push_back('{err: 1'b1, rdata: 32'h0});
      issue(1'b0, 2'd2, 1'b0, 32'h300, 32'h0);
      n = 0; seen = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (core_done) begin seen = 1'b1; break; end
         if (bus_req) n++;
         step();
      end
      e = sb.pop_front();
      total++;
      if (!seen || n != 16 || core_err !== e.err || bus_req !== 1'b0) begin
         bad++; $display("FAIL to_expire seen=%0d req_cycles=%0d err=%b req=%b want 1 16 1 0", seen, n, core_err, bus_req);
      end
      step();
      bus_rvalid = 1'b1; bus_rdata = 32'hFFFFFFFF;
      step();
      bus_rvalid = 1'b0;
      total++;
      if (core_done !== 1'b0 || core_busy !== 1'b0) begin
         bad++; $display("FAIL to_late_rvalid done=%b busy=%b want 0 0", core_done, core_busy);
      end
      sb.push_back('{err: 1'b0, rdata: 32'h0BADF00D});
      issue(1'b0, 2'd2, 1'b0, 32'h104, 32'h0);
      bus_gnt = 1'b1;
      step();
      bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h0BADF00D;
      step();
      bus_rvalid = 1'b0;
      e = sb.pop_front();
      total++;
      if ({core_done, core_err, core_rdata} !== {1'b1, e.err, e.rdata}) begin
         bad++; $display("FAIL to_recover done=%b err=%b rdata=%h want 1 0 0badf00d", core_done, core_err, core_rdata);
      end
      step();
      sb.push_back('{err: 1'b0, rdata: 32'h0});
      issue(1'b1, 2'd2, 1'b0, 32'h108, 32'h55AA55AA);
      for (int k = 0; k < 15; k++) step();
      bus_gnt = 1'b1;
      total++;
      if (bus_req !== 1'b1) begin
         bad++; $display("FAIL to_last_req req=%b want 1", bus_req);
      end
      step();
      bus_gnt = 1'b0;
      e = sb.pop_front();
      total++;
      if ({core_done, core_err} !== {1'b1, e.err}) begin
         bad++; $display("FAIL to_gnt_wins done=%b err=%b want 1 0", core_done, core_err);
      end
      step();
   endtask

   task automatic test_reset_mid();
      exp_t e;
      issue(1'b0, 2'd2, 1'b0, 32'h400, 32'h0);
      bus_gnt = 1'b1;
      step();
      bus_gnt = 1'b0;
      sys_rst = 1'b1;
      step();
      sys_rst = 1'b0;
      total++;
      if ({core_busy, core_done, core_err, bus_req, core_rdata} !== 36'h0) begin
         bad++; $display("FAIL rm_reset busy=%b done=%b err=%b req=%b rdata=%h want all 0",
                         core_busy, core_done, core_err, bus_req, core_rdata);
      end
      bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
      for (int k = 0; k < 3; k++) begin
         step();
         total++;
         if (core_done !== 1'b0) begin
            bad++; $display("FAIL rm_no_done cyc=%0d done=%b want 0", k, core_done);
         end
      end
      bus_rvalid = 1'b0;
      sb.push_back('{err: 1'b0, rdata: 32'h0000ABCD});
      issue(1'b0, 2'd1, 1'b1, 32'h406, 32'h0);
      bus_gnt = 1'b1;
      step();
      bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hABCD0000;
      step();
      bus_rvalid = 1'b0;
      e = sb.pop_front();
      total++;
      if ({core_done, core_err, core_rdata} !== {1'b1, e.err, e.rdata}) begin
         bad++; $display("FAIL rm_after done=%b err=%b rdata=%h want 1 0 0000abcd", core_done, core_err, core_rdata);
      end
      step();
   endtask

   task automatic test_back_to_back();
      exp_t        e;
      logic [1:0]  sz, off;
      logic        we, uns;
      logic [31:0] addr, wd, rd, sh, exp_rd;
      logic [3:0]  exp_be;
      int          gd, rdl;
      bit          seen;
      for (int i = 0; i < 12; i++) begin
         sz  = 2'($urandom_range(0, 2));
         off = 2'($urandom_range(0, 3));
         if (sz == 2'd1) off[0] = 1'b0;
         if (sz == 2'd2) off = 2'd0;
         we   = 1'($urandom_range(0, 1));
         uns  = 1'($urandom_range(0, 1));
         addr = 32'h500 + 32'(16 * i) + 32'(off);
         wd   = $urandom();
         rd   = $urandom();
         gd   = $urandom_range(0, 3);
         rdl  = $urandom_range(0, 3);
         sh   = rd >> (8 * off);
         if (sz == 2'd0)      exp_rd = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
         else if (sz == 2'd1) exp_rd = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         else                 exp_rd = sh;
         exp_be = (sz == 2'd0) ? 4'h1 : (sz == 2'd1) ? 4'h3 : 4'hF;
         exp_be = exp_be << off;
         sb.push_back('{err: 1'b0, rdata: we ? 32'h0 : exp_rd});
         issue(we, sz, uns, addr, wd);
         core_req = 1'b1; core_addr = 32'h1; core_size = 2'd2;
         total++;
         if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata} !== {1'b1, we, addr & 32'hFFFFFFFC, exp_be, we ? (wd << (8 * off)) : (wd << (8 * off))}) begin
            bad++; $display("FAIL b2b_bus_%0d req=%b we=%b addr=%h be=%h wdata=%h want 1 %b %h %h %h", i, bus_req, bus_we,
                            bus_addr, bus_be, bus_wdata, we, addr & 32'hFFFFFFFC, exp_be, wd << (8 * off));
         end
         for (int k = 0; k < gd; k++) step();
         bus_gnt = 1'b1;
         step();
         bus_gnt = 1'b0;
         if (!we) begin
            for (int k = 0; k < rdl; k++) step();
            bus_rvalid = 1'b1; bus_rdata = rd;
            step();
            bus_rvalid = 1'b0;
         end
         seen = 1'b0;
         for (int k = 0; k < 5; k++) begin
            if (core_done) begin seen = 1'b1; break; end
            step();
         end
         core_req = 1'b0;
         total++;
         if (sb.size() == 0) begin
            bad++; $display("FAIL b2b_sb_%0d scoreboard empty", i);
         end else begin
            e = sb.pop_front();
            if (!seen || core_err !== e.err || core_rdata !== e.rdata) begin
               bad++; $display("FAIL b2b_done_%0d seen=%0d err=%b rdata=%h want 1 %b %h", i, seen, core_err, core_rdata, e.err, e.rdata);
            end
         end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_word_load();
      test_byte_load();
      test_half_store();
      test_misaligned();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
